// File: rtl/cci_mpf_prim_fifo_arb_pkg.sv
// Shared types and helpers for the FIFO enqueue arbiter and its round-robin selector.

package cci_mpf_prim_fifo_arb_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        DONE  = 2'd2
    } arb_state_e;

    // Width of a requester index; never less than one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/cci_mpf_prim_arb_rr.sv
// Combinational round-robin selector: the first set request at or after ptr_i wins,
// with the search wrapping from N_REQ-1 back to 0.

module cci_mpf_prim_arb_rr
    import cci_mpf_prim_fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N_REQ-1:0] grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    logic [IDX_W-1:0] cand;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IDX_W'((32'(ptr_i) + k) % N_REQ);
            if (!valid_o && req_i[cand]) begin
                grant_o[cand] = 1'b1;
                idx_o         = cand;
                valid_o       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/cci_mpf_prim_fifo_enq_arb.sv
// Arbitrates N_REQ requesters onto one FIFO enqueue port with a registered enqueue stage
// and a stop-and-drain flush sequence (RUN -> DRAIN -> DONE -> RUN).

module cci_mpf_prim_fifo_enq_arb
    import cci_mpf_prim_fifo_arb_pkg::*;
#(
    parameter int unsigned N_REQ       = 4,
    parameter int unsigned N_DATA_BITS = 32
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [N_REQ-1:0]                      req_valid,
    input  logic [N_REQ-1:0][N_DATA_BITS-1:0]     req_data,
    output logic [N_REQ-1:0]                      req_grant,
    output logic [N_DATA_BITS-1:0]                fifo_enq_data,
    output logic [idx_width(N_REQ)-1:0]           fifo_enq_tag,
    output logic                                  fifo_enq_en,
    input  logic                                  fifo_notFull,
    input  logic                                  fifo_almostFull,
    input  logic                                  fifo_notEmpty,
    input  logic                                  flush_req,
    output logic                                  flush_done
);

    localparam int unsigned IdxW = idx_width(N_REQ);

    arb_state_e             state_q, state_d;
    logic [IdxW-1:0]        ptr_q, ptr_d;
    logic                   enq_en_q, enq_en_d;
    logic [N_DATA_BITS-1:0] enq_data_q, enq_data_d;
    logic [IdxW-1:0]        enq_tag_q, enq_tag_d;

    logic [N_REQ-1:0]       arb_grant;
    logic [IdxW-1:0]        arb_idx;
    logic                   arb_valid;
    logic                   grant_ok;
    logic                   do_grant;

    cci_mpf_prim_arb_rr #(
        .N_REQ (N_REQ),
        .IDX_W (IdxW)
    ) u_arb_rr (
        .req_i   (req_valid),
        .ptr_i   (ptr_q),
        .grant_o (arb_grant),
        .idx_o   (arb_idx),
        .valid_o (arb_valid)
    );

    // Reset gates the grant so it drops at once, without waiting for an edge.
    always_comb begin
        grant_ok  = !reset && (state_q == RUN) && !flush_req &&
                    fifo_notFull && !fifo_almostFull;
        req_grant = grant_ok ? arb_grant : '0;
        do_grant  = grant_ok && arb_valid;
    end

    always_comb begin
        ptr_d      = ptr_q;
        enq_en_d   = do_grant;
        enq_data_d = enq_data_q;
        enq_tag_d  = enq_tag_q;
        if (do_grant) begin
            ptr_d      = (arb_idx == IdxW'(N_REQ - 1)) ? '0 : arb_idx + 1'b1;
            enq_data_d = req_data[arb_idx];
            enq_tag_d  = arb_idx;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (flush_req) state_d = DRAIN;
            // Drained once nothing is in flight to the FIFO and the FIFO is empty.
            DRAIN:   if (!enq_en_q && !fifo_notEmpty) state_d = DONE;
            DONE:    state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            ptr_q      <= '0;
            enq_en_q   <= 1'b0;
            enq_data_q <= '0;
            enq_tag_q  <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            enq_en_q   <= enq_en_d;
            enq_data_q <= enq_data_d;
            enq_tag_q  <= enq_tag_d;
        end
    end

    assign fifo_enq_en   = enq_en_q;
    assign fifo_enq_data = enq_data_q;
    assign fifo_enq_tag  = enq_tag_q;
    assign flush_done    = (state_q == DONE);

    enq_overflow_a: assert property (@(posedge clk) disable iff (reset)
        fifo_enq_en |-> fifo_notFull)
        else $fatal(1, "enqueue into a full FIFO");

endmodule
